dm_arbiter: RTL

//  Shares the single-port byte-enabled data memory between two masters:
//  M0 = CPU MEM stage (priority), M1 = DMA/debug loader (lockable bursts).

---
 rtl/dm_arbiter_if.sv | 62 ++++++
 rtl/dm_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/dm_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dm_arbiter_if
// Brief    : Request/response bundle between the two data-memory masters
//            (CPU MEM stage and DMA/debug loader), the arbiter, and the
//            single-port byte-enabled data memory.
// Revision : 1.0 - initial release
// ============================================================================
interface dm_arbiter_if;
  // M0: CPU MEM stage
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [3:0]  m0_be;
  logic [31:0] m0_wdata;
  logic [31:0] m0_pc4;
  logic        m0_ack;
  logic        m0_stall;
  logic        m0_err;
  // M1: DMA / debug loader
  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [3:0]  m1_be;
  logic [31:0] m1_wdata;
  logic        m1_lock;
  logic        m1_ack;
  logic        m1_err;
  // Shared read data and status
  logic [31:0] rdata;
  logic        err_sticky;
  // Data memory port
  logic        dm_we;
  logic [31:0] dm_a;
  logic [3:0]  dm_be;
  logic [31:0] dm_wd;
  logic [31:0] dm_pc4;
  logic [31:0] dm_rd;

  // Arbiter side: takes requests and memory read data, drives everything else
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_be, m0_wdata, m0_pc4,
    input  m1_req, m1_we, m1_addr, m1_be, m1_wdata, m1_lock,
    input  dm_rd,
    output m0_ack, m0_stall, m0_err,
    output m1_ack, m1_err,
    output rdata, err_sticky,
    output dm_we, dm_a, dm_be, dm_wd, dm_pc4
  );

  // Requester / memory-model side
  modport master (
    output m0_req, m0_we, m0_addr, m0_be, m0_wdata, m0_pc4,
    output m1_req, m1_we, m1_addr, m1_be, m1_wdata, m1_lock,
    output dm_rd,
    input  m0_ack, m0_stall, m0_err,
    input  m1_ack, m1_err,
    input  rdata, err_sticky,
    input  dm_we, dm_a, dm_be, dm_wd, dm_pc4
  );
endinterface
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dm_arbiter
// Brief    : Two-master arbiter for the single-port data memory. M0 (CPU)
//            has priority, M1 (loader) gets a starvation guard and bounded
//            locked bursts. Illegal stores are consumed but never written.
// Revision : 1.0 - initial release
// ============================================================================
module dm_arbiter #(
  parameter int DM_WORDS   = 4096,
  parameter int STARVE_MAX = 4,
  parameter int LOCK_MAX   = 8
) (
  input  logic        clk,
  input  logic        reset,
  dm_arbiter_if.slave bus
);

  localparam int C_WAIT_W = $clog2(STARVE_MAX + 1);
  localparam int C_BEAT_W = $clog2(LOCK_MAX + 1);
  localparam logic [C_WAIT_W-1:0] C_WAIT_MAX   = C_WAIT_W'(STARVE_MAX);
  localparam logic [C_BEAT_W-1:0] C_BEAT_MAX   = C_BEAT_W'(LOCK_MAX);
  localparam logic [C_BEAT_W-1:0] C_BEAT_FIRST = C_BEAT_W'(1);
  // One bit wider than the address so the byte limit never wraps
  localparam logic [32:0]         C_ADDR_LIMIT = 33'(DM_WORDS) << 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [C_WAIT_W-1:0] r_wait_cnt;
  logic [C_WAIT_W-1:0] w_wait_nxt;
  logic [C_BEAT_W-1:0] r_beat_cnt;
  logic [C_BEAT_W-1:0] w_beat_nxt;
  logic                r_err_sticky;

  logic        w_gnt_m0;
  logic        w_gnt_m1;
  logic        w_gnt_any;
  logic        w_sel_we;
  logic [31:0] w_sel_addr;
  logic [3:0]  w_sel_be;
  logic [31:0] w_sel_wdata;
  logic        w_legal;
  logic        w_reject;

  // Store legality: natural alignment of the lane pattern plus range check.
  // Only the seven lane/offset pairs the MEM stage can produce are accepted.
  function automatic logic store_legal(input logic [31:0] addr, input logic [3:0] be);
    logic lane_ok;
    case ({be, addr[1:0]})
      6'b1111_00, 6'b0011_00, 6'b1100_10,
      6'b0001_00, 6'b0010_01, 6'b0100_10, 6'b1000_11: lane_ok = 1'b1;
      default:                                        lane_ok = 1'b0;
    endcase
    return lane_ok && ({1'b0, addr} < C_ADDR_LIMIT);
  endfunction

  // Grant decision: combinational from requests and registered arbiter state
  always_comb begin
    w_gnt_m0 = 1'b0;
    w_gnt_m1 = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_LOCK: begin
          // Burst owner keeps the port until it hits the beat limit; a forced
          // release with no M0 request leaves a one-cycle bubble.
          if (bus.m1_req && (r_beat_cnt < C_BEAT_MAX)) w_gnt_m1 = 1'b1;
          else if (bus.m0_req)                         w_gnt_m0 = 1'b1;
        end
        default: begin
          if (bus.m1_req && (r_wait_cnt == C_WAIT_MAX)) w_gnt_m1 = 1'b1;
          else if (bus.m0_req)                          w_gnt_m0 = 1'b1;
          else if (bus.m1_req)                          w_gnt_m1 = 1'b1;
        end
      endcase
    end
  end

  assign w_gnt_any   = w_gnt_m0 | w_gnt_m1;
  assign w_sel_we    = w_gnt_m1 ? bus.m1_we    : bus.m0_we;
  assign w_sel_addr  = w_gnt_m1 ? bus.m1_addr  : bus.m0_addr;
  assign w_sel_be    = w_gnt_m1 ? bus.m1_be    : bus.m0_be;
  assign w_sel_wdata = w_gnt_m1 ? bus.m1_wdata : bus.m0_wdata;
  assign w_legal     = store_legal(w_sel_addr, w_sel_be);
  assign w_reject    = w_gnt_any & w_sel_we & ~w_legal;

  // Requester responses; a rejected store still consumes the access
  assign bus.m0_ack     = w_gnt_m0;
  assign bus.m1_ack     = w_gnt_m1;
  assign bus.m0_stall   = bus.m0_req & ~w_gnt_m0;
  assign bus.m0_err     = w_gnt_m0 & w_reject;
  assign bus.m1_err     = w_gnt_m1 & w_reject;
  assign bus.rdata      = bus.dm_rd;
  assign bus.err_sticky = r_err_sticky;

  // Memory port is driven to zero whenever nobody holds the grant
  assign bus.dm_we  = w_gnt_any & w_sel_we & w_legal;
  assign bus.dm_a   = w_gnt_any ? w_sel_addr  : 32'd0;
  assign bus.dm_be  = w_gnt_any ? w_sel_be    : 4'd0;
  assign bus.dm_wd  = w_gnt_any ? w_sel_wdata : 32'd0;
  assign bus.dm_pc4 = w_gnt_m0  ? bus.m0_pc4  : 32'd0;

  // Next-state: lock tracking, burst beat count and M1 starvation counter
  always_comb begin
    w_state_nxt = ST_IDLE;
    w_beat_nxt  = '0;
    w_wait_nxt  = '0;
    if (w_gnt_m1 && bus.m1_lock) begin
      w_state_nxt = ST_LOCK;
      w_beat_nxt  = (r_state == ST_LOCK) ? r_beat_cnt + 1'b1 : C_BEAT_FIRST;
    end
    if (bus.m1_req && !w_gnt_m1) begin
      w_wait_nxt = (r_wait_cnt == C_WAIT_MAX) ? r_wait_cnt : r_wait_cnt + 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_wait_cnt   <= '0;
      r_beat_cnt   <= '0;
      r_err_sticky <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wait_cnt   <= w_wait_nxt;
      r_beat_cnt   <= w_beat_nxt;
      r_err_sticky <= r_err_sticky | w_reject;
    end
  end

endmodule
`default_nettype wire
